// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and constants for the unified memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_DATA = 2'd2
    } resp_sel_t;

    localparam int MASK_W   = 8;
    localparam int DW_SHIFT = 3;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one doubleword memory port between instruction fetch and load/store
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  r_starve_cnt;
    resp_sel_t         r_resp_sel;
    resp_sel_t         w_resp_next;
    logic [31:0]       r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_force_if;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic              w_load_gnt;
    logic              w_unused;

    // Data port has priority; a fetch that has waited STARVE_MAX cycles takes one slot.
    assign w_force_if = if_req && (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_if_gnt   = !rst && if_req && (!d_req || w_force_if);
    assign w_d_gnt    = !rst && d_req && !w_force_if;
    assign w_load_gnt = w_d_gnt && !d_we;
    assign if_gnt     = w_if_gnt;
    assign d_gnt      = w_d_gnt;
    assign w_unused   = ^{if_addr[1:0], d_addr[2:0]};

    always_comb begin
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (w_if_gnt) begin
            mem_addr = ADDR_W'(if_addr >> DW_SHIFT);
        end else if (w_d_gnt) begin
            mem_addr  = ADDR_W'(d_addr >> DW_SHIFT);
            mem_wr_en = d_we;
            if (d_we) begin
                mem_wdata = d_wdata;
                mem_wmask = d_wmask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!if_req || w_if_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_sel <= RESP_NONE;
        end else begin
            r_resp_sel <= w_resp_next;
        end
    end

    always_comb begin
        w_resp_next = RESP_NONE;
        if (w_if_gnt) begin
            w_resp_next = RESP_IF;
        end else if (w_load_gnt) begin
            w_resp_next = RESP_DATA;
        end
    end

    always_comb begin
        if_rvalid = (r_resp_sel == RESP_IF);
        d_rvalid  = (r_resp_sel == RESP_DATA);
    end

    // Read data is captured at the grant edge; the lane select for fetch is taken then too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (w_if_gnt) begin
                r_if_rdata <= if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
            end
            if (w_load_gnt) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

endmodule
